// File: rtl/arcade_ctrl_mapper_pkg.sv
// arcade_ctrl_mapper_pkg: mode codes, joystick bit map, coin FSM states and tread mapping
package arcade_ctrl_pkg;
  localparam logic [7:0] MODE_BATTLEZONE = 8'd0;
  localparam logic [7:0] MODE_BRADLEY = 8'd1;
  localparam logic [7:0] MODE_ANALOG = 8'd2;
  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;
  localparam int JOY_FIRE = 4;
  localparam int JOY_START1 = 5;
  localparam int JOY_START2 = 6;
  localparam int JOY_COIN = 7;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_WAIT_REL} coin_state_t;
  // input is {U,D,L,R}, result is {LF,LB,RF,RB}
  function automatic logic [3:0] tread_map(input logic [3:0] udlr);
    case (udlr)
      4'b1000: return 4'b1010;
      4'b1010: return 4'b0010;
      4'b1001: return 4'b1000;
      4'b0001: return 4'b1001;
      4'b0101: return 4'b0100;
      4'b0100: return 4'b0101;
      4'b0110: return 4'b0001;
      4'b0010: return 4'b0110;
      default: return 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/arcade_ctrl_mapper_if.sv
// arcade_ctrl_mapper_if: ioctl download bus from hps_io into the control mapper
interface arcade_ctrl_mapper_if;
  logic ioctl_wr;
  logic [7:0] ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0] ioctl_dout;
  modport master (output ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
  modport slave (input ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout);
endinterface

// File: rtl/arcade_ctrl_mapper_coin.sv
// coin_pulser: fixed-width coin pulse per press, re-armed only after release
module coin_pulser
  import arcade_ctrl_pkg::*;
#(
  parameter int COIN_PULSE = 16
) (
  input logic clk_i,
  input logic btnCpuReset,
  input logic coin_in,
  output logic pulse_o
);
  localparam int CW = COIN_PULSE > 1 ? $clog2(COIN_PULSE) : 1;
  coin_state_t state;
  logic [CW-1:0] cnt;
  logic prev;
  // prev is primed during reset so a coin held across reset release is not an edge
  always_ff @(posedge clk_i) begin
    if (!btnCpuReset) begin
      state <= ST_IDLE;
      cnt <= '0;
      prev <= coin_in;
      pulse_o <= 1'b0;
    end else begin
      prev <= coin_in;
      case (state)
        ST_IDLE: if (coin_in && !prev) begin
          state <= ST_PULSE;
          cnt <= CW'(COIN_PULSE - 1);
          pulse_o <= 1'b1;
        end
        ST_PULSE: if (cnt == '0) begin
          state <= ST_WAIT_REL;
          pulse_o <= 1'b0;
        end else cnt <= cnt - 1'b1;
        ST_WAIT_REL: if (!coin_in) state <= ST_IDLE;
        default: begin
          state <= ST_IDLE;
          pulse_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/arcade_ctrl_mapper.sv
// arcade_ctrl_mapper: ioctl config capture, joystick merge and per-mode button mapping.
// ARCADE_CTRL_DEADZONE_EN adds a centre dead zone to the analog axis byte.
module arcade_ctrl_mapper
  import arcade_ctrl_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_DSW = 8,
  parameter int DSW_INDEX = 254,
  parameter int MODE_INDEX = 1,
  parameter int COIN_PULSE = 16,
  parameter int DEADZONE = 8
) (
  input logic clk_i,
  input logic btnCpuReset,
  arcade_ctrl_mapper_if.slave ioctl,
  input logic [16*NUM_PLAYERS-1:0] joy_i,
  input logic [16*NUM_PLAYERS-1:0] joya_i,
  input logic analog_sel_i,
  output logic [7:0] mode_o,
  output logic [8*NUM_DSW-1:0] dsw_o,
  output logic [7:0] jb_o,
  output logic [7:0] buttons_o,
  output logic [7:0] aux_o
);
  // config survives reset since the core is held in reset while downloading
  logic [7:0] mode_q = 8'hFF;
  logic [NUM_DSW-1:0][7:0] dsw_q = '0;
  always_ff @(posedge clk_i) begin
    if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'(MODE_INDEX)) mode_q <= ioctl.ioctl_dout;
    for (int n = 0; n < NUM_DSW; n++)
      if (ioctl.ioctl_wr && ioctl.ioctl_index == 8'(DSW_INDEX) && ioctl.ioctl_addr == 25'(n))
        dsw_q[n] <= ioctl.ioctl_dout;
  end
  assign mode_o = mode_q;
  assign dsw_o = dsw_q;
  logic [7:0] joy_or, joy_q;
  logic [15:0] joya_q;
  logic sel_q, coin, analog;
  logic [3:0] tread;
  logic [7:0] axis, axis_out;
  logic unused_bits;
  always_comb begin
    joy_or = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) joy_or = joy_or | joy_i[16*p +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (!btnCpuReset) begin
      joy_q <= '0;
      joya_q <= '0;
      sel_q <= 1'b0;
    end else begin
      joy_q <= joy_or;
      joya_q <= joya_i[15:0];
      sel_q <= analog_sel_i;
    end
  end
  // the pulser's state register doubles as the stage-1 coin register
  coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin (
    .clk_i(clk_i),
    .btnCpuReset(btnCpuReset),
    .coin_in(joy_or[JOY_COIN]),
    .pulse_o(coin)
  );
  assign analog = mode_q == MODE_ANALOG;
  assign tread = tread_map(joy_q[3:0]);
  assign axis = sel_q ? joya_q[7:0] : joya_q[15:8];
`ifdef ARCADE_CTRL_DEADZONE_EN
  logic [7:0] mag;
  assign mag = axis[7] ? 8'(-axis) : axis;
  assign axis_out = mag < 8'(DEADZONE) ? 8'h80 : axis ^ 8'h80;
`else
  assign axis_out = axis ^ 8'h80;
`endif
  assign unused_bits = ^{joy_i, joya_i, joy_q[JOY_COIN], 8'(DEADZONE)};
  always_ff @(posedge clk_i) begin
    if (!btnCpuReset) begin
      jb_o <= {analog, 7'b0};
      buttons_o <= '0;
      aux_o <= '0;
    end else begin
      jb_o <= analog
        ? {~coin, joy_q[JOY_START1], joy_q[JOY_START2], joy_q[JOY_FIRE],
           joy_q[JOY_D], joy_q[JOY_U], joy_q[JOY_R], joy_q[JOY_L]}
        : {coin, joy_q[JOY_START1], joy_q[JOY_START2], joy_q[JOY_FIRE], tread};
      buttons_o <= analog ? axis_out
        : {2'b00, joy_q[JOY_START1], joy_q[JOY_START2] | joy_q[JOY_FIRE], tread};
      aux_o <= analog ? {joy_q[JOY_FIRE], joy_q[JOY_START1], 6'b0} : 8'h00;
    end
  end
endmodule

// File: doc/arcade_ctrl_mapper.md
# arcade_ctrl_mapper

Parametrised control-input front end between `hps_io` and the game core (`top`). It captures the game-mode byte and DIP-switch bytes from the ioctl download stream, merges joysticks from `NUM_PLAYERS` players, and maps them per mode into the POKEY switch byte, the arcade-button byte and the auxiliary button byte. Tank mode converts an 8-way stick into dual-tread signals; analog mode produces an offset-binary, optionally dead-zoned axis byte. Coin is a fixed-width pulse with a re-arm FSM.

## Interface

**Parameters**
- `NUM_PLAYERS`, default 2: joystick sets merged, 1..4.
- `NUM_DSW`, default 8: DIP bytes captured, 1..8.
- `DSW_INDEX`, default 254: ioctl index carrying DIP bytes.
- `MODE_INDEX`, default 1: ioctl index carrying the mode byte.
- `COIN_PULSE`, default 16: coin pulse width in `clk_i` cycles, ≥1.
- `DEADZONE`, default 8: analog magnitude treated as centre, 0..127.

**Ports**
- `clk_i` in 1: the single clock.
- `btnCpuReset` in 1: reset, synchronous, active-low.
- `ioctl_wr` in 1: download write strobe.
- `ioctl_index` in 8: download index.
- `ioctl_addr` in 25: download byte address.
- `ioctl_dout` in 8: download byte.
- `joy_i` in 16*NUM_PLAYERS: digital joysticks. Bits are [0]R, [1]L, [2]D, [3]U, [4]fire, [5]start1, [6]start2, [7]coin.
- `joya_i` in 16*NUM_PLAYERS: analog sticks. [7:0] is X and [15:8] is Y, both signed.
- `analog_sel_i` in 1: 1 selects X, 0 selects Y. Driven by the game's `audiosel[0]`.
- `mode_o` out 8: captured mode byte.
- `dsw_o` out 8*NUM_DSW: DIP bytes, byte n at [8n+7:8n].
- `jb_o` out 8: POKEY switch byte.
- `buttons_o` out 8: arcade buttons or analog byte.
- `aux_o` out 8: auxiliary buttons.

## Operation

- **Config registers (`mode_o`, `dsw_o`)**
  - Not affected by `btnCpuReset`, because reset is held during download. Power-up values: `mode_o`=8'hFF, `dsw_o`=0.
  - `ioctl_wr && ioctl_index==MODE_INDEX` loads `mode_o`. The last byte wins and the address is ignored.
  - `ioctl_wr && ioctl_index==DSW_INDEX && ioctl_addr < NUM_DSW` loads byte `ioctl_addr`. Out-of-range addresses are dropped.
- **Input merge**
  - `joy` is the bitwise OR of all player words, registered in stage 1.
  - The `joya_i` slice used is player 0's.
- **Tread map**
  - Uses `joy[3:0]` (U,D,L,R) to produce {LF,LB,RF,RB}:
    - U → 1010
    - U+L → 0010
    - U+R → 1000
    - R → 1001
    - D+R → 0100
    - D → 0101
    - D+L → 0001
    - L → 0110
    - any other pattern, including none or U+D → 0000.
- **Mode decode**
  - `MODE_ANALOG`=2.
  - Every other value, including 0, 1 and 8'hFF, is tank mode.
- **Tank mode**
  - `jb_o` = {coin, joy[5], joy[6], joy[4], tread}.
  - `buttons_o` = {2'b00, joy[5], joy[6]|joy[4], tread}.
  - `aux_o` = 0.
- **Analog mode**
  - `jb_o` = {~coin, joy[5], joy[6], joy[4], joy[2], joy[3], joy[0], joy[1]}.
  - `buttons_o` = selected axis XOR 8'h80, i.e. signed to offset binary.
  - `aux_o` = {joy[4], joy[5], 6'b0}.
- **Coin FSM**
  - States are IDLE, PULSE and WAIT_REL.
  - IDLE→PULSE on a rising edge of registered `joy[7]`; the counter loads `COIN_PULSE-1`.
  - PULSE counts down, then goes to WAIT_REL at 0.
  - WAIT_REL→IDLE when `joy[7]`=0.
  - A press held through the pulse gives exactly one pulse. Edges during PULSE are ignored.
  - `coin` is 1 only in PULSE.

## Timing

- Latency is 2 cycles for all outputs: stage 1 is the input register, stage 2 is the output register. This applies from `joy_i`, `joya_i` and `analog_sel_i` alike.
- Coin rise: `jb_o[7]` asserts 2 cycles after `joy_i` bit 7 rises and stays asserted for exactly `COIN_PULSE` cycles.
- A `mode_o` change takes effect on the output mapping 1 cycle after the write.
- **Reset** (synchronous, on a clock edge with `btnCpuReset`=0):
  - FSM goes to IDLE and the pipeline is cleared.
  - `jb_o` = {(mode_o==MODE_ANALOG), 7'b0}, i.e. coin at its inactive level.
  - `buttons_o` = 0 and `aux_o` = 0.
  - Reset during PULSE aborts the pulse.
  - After release, a stick that is still held does not produce a coin, because the edge detector is primed with the current level.

## Configuration

- Macro: `ARCADE_CTRL_DEADZONE_EN`.
- **Defined**: in analog mode, a selected axis with |a| < `DEADZONE` outputs 8'h80. The magnitude of −128 is taken as 128.
- **Undefined**: no deadzone. The `DEADZONE` parameter is ignored and `buttons_o` = a XOR 8'h80 exactly.
- Latency is 2 cycles in both builds.

## Structure

- **Package `arcade_ctrl_pkg`** holds:
  - the `MODE_BATTLEZONE`=0, `MODE_BRADLEY`=1 and `MODE_ANALOG`=2 constants;
  - the coin FSM state enum;
  - the `JOY_*` bit-index constants;
  - a tread-map function.
- **Sub-module `coin_pulser`** contains the FSM and counter, with ports `clk_i`, `btnCpuReset`, `coin_in`, `pulse_o` and parameter `COIN_PULSE`.

## Test plan

- **Config capture**: write index 254 at addr 0..8 with data 8'h11..8'h99 while reset is held → `dsw_o` bytes 0..7 = 11..88 and addr 8 is dropped. Then write index 1 with 8'h02 → `mode_o`=02.
- **Tread table**: mode 0, sweep all 16 values of `joy_i[3:0]` → `jb_o[3:0]` matches the table 2 cycles later. U+D gives 0000.
- **Player merge**: `NUM_PLAYERS`=2, P1 presses fire and P2 presses start2 → `buttons_o[4]`=1 and `jb_o[5]`=1.
- **Coin**: `COIN_PULSE`=16, hold coin for 100 cycles → exactly one 16-cycle pulse. Release and press again → a second pulse. Mode 2 shows the same pulses inverted.
- **Analog**: mode 2, X=8'h05, Y=8'hF0, sel=1 → `buttons_o`=8'h85, or 8'h80 with `ARCADE_CTRL_DEADZONE_EN` defined. sel=0 → 8'h70 in both builds.
- **Reset mid-pulse**: assert `btnCpuReset`=0 at cycle 5 of a pulse → `jb_o`=0 next edge. Release with coin still held → no pulse.
